fifo_packetizer: RTL
====================

# fifo_packetizer

Read-side consumer of the team's `fifo`/`ring_fifo` read port. It drains words from a FIFO and emits them as packets on a valid/ready stream, framed with `out_first` and `out_last`. A packet closes when it reaches `MAX_LEN` words, or when the FIFO stays empty for `TIMEOUT` cycles after the last word popped. It sits between a FIFO and any downstream framed-stream sink.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `MAX_LEN`, 16, maximum words per packet; ≥1.
- `TIMEOUT`, 32, idle cycles before a short packet closes; ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `fifo_val`  in  1  FIFO holds a word; `fifo_dataout` is valid (first-word-fall-through).
- `fifo_dataout`  in  DATA_WIDTH  FIFO head word.
- `fifo_read`  out  1  pop strobe to FIFO.
- `out_data`  out  DATA_WIDTH  packet word.
- `out_valid`  out  1  `out_data`/flags valid.
- `out_ready`  in  1  sink accepts the word when `out_valid & out_ready` at a rising edge.
- `out_first`  out  1  first word of packet.
- `out_last`  out  1  last word of packet.

## Operation
- FIFO read rule: a pop is legal only when `fifo_val=1`. `fifo_read` is never high on two consecutive cycles, because the FIFO head is not valid in the cycle after a pop. `fifo_dataout` is captured on the same edge as the pop.
- State: one hold register `H`, word counter `cnt` (0..MAX_LEN, width $clog2(MAX_LEN+1)), idle timer `t` (0..TIMEOUT-1).
- FSM `IDLE`/`HOLD`/`SEND`:
  - IDLE: `fifo_read = fifo_val`. On a pop: `H<=fifo_dataout`, `cnt<=cnt+1`, `t<=0`, go to HOLD.
  - HOLD: no pop; `t` increments. The `last` decision, in priority order:
    - `cnt==MAX_LEN` → last=1.
    - else `fifo_val=1` → last=0.
    - else `t==TIMEOUT-1` → last=1.
    - else stay in HOLD.
    - On any decision, go to SEND.
  - SEND: `out_valid=1`, `out_data=H`, `out_first=(cnt==1)`, `out_last=last`. Hold all of these until `out_ready`. On acceptance:
    - last=1: `cnt<=0`, go to IDLE.
    - last=0: `fifo_read=1` in the accepting cycle, `H<=fifo_dataout`, `cnt<=cnt+1`, `t<=0`, go to HOLD.
- `fifo_read` is combinational from state, `fifo_val` and `out_ready`. All other outputs are registered or decoded from state; no combinational path from `out_ready` to `out_valid`.
- `fifo_val` cannot fall without a pop, so the last=0 decision is always honoured.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_first=0`, `out_last=0`, `fifo_read=0`, state IDLE, `cnt=0`, `t=0`.
- Reset mid-packet: outputs clear immediately. Any word in `H` is discarded. After release the next word starts a new packet with `out_first=1`.
- Latency from FIFO pop to `out_valid`:
  - 2 cycles if the next word is present or `cnt==MAX_LEN`.
  - TIMEOUT+1 cycles if the packet closes by timeout.
- Peak throughput: 1 word / 2 cycles, which matches the FIFO read spacing.
- Boundaries:
  - `MAX_LEN=1`: every word is first and last.
  - A word arriving during HOLD before the timeout expires extends the packet.
  - Backpressure holds the SEND state indefinitely with no pops.
- Assertions:
  - `fifo_read` never high on consecutive cycles.
  - `fifo_read` implies `fifo_val`.
  - `cnt ≤ MAX_LEN`.
  - Outputs are stable while `out_valid & ~out_ready`.

## Structure
- Shared package: the state enum (IDLE/HOLD/SEND) and the counter-width helper.
- Single module; no sub-module. The idle timer is inline.

## Test plan
Parameters: DATA_WIDTH=8, MAX_LEN=4, TIMEOUT=8, paired with a 16-deep `fifo`.
- Reset: hold reset 3 cycles → all outputs 0, no `fifo_read`.
- Preload 0x11, 0x22, 0x33; `out_ready=1` → one packet: 0x11 with first=1; 0x33 with last=1, presented 8 idle cycles after its pop.
- Preload 0x01..0x06 → packet A is 01..04 with last on 04 (MAX_LEN, no wait). Packet B is 05, 06 with first on 05 and last on 06 after the timeout.
- Push 0xAA; push 0xBB 5 cycles after 0xAA pops → single packet: AA (first=1, last=0), BB (last=1).
- 0x5C presented with `out_ready=0` for 10 cycles → `out_data`/flags stable, `fifo_read=0` throughout; accepted on the cycle `out_ready` rises.
- Random FIFO writes plus random `out_ready`; reset asserted during SEND → `out_valid` drops immediately; the next packet starts with first=1. A scoreboard confirms word order, packet sizes ≤4, and that the assertions never fire.

Source files
------------

// File: rtl/fifo_packetizer_pkg.sv
// Shared definitions for the FIFO packetizer: FSM state encoding and the
// helper that sizes counters from their maximum value.
package fifo_packetizer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOLD = 2'd1;
    localparam state_t ST_SEND = 2'd2;

    // Bits needed to hold the values 0..max_count (never less than one bit)
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_packetizer.sv
// Drains a first-word-fall-through FIFO and emits its words as framed packets
// on a valid/ready stream. A packet closes at MAX_LEN words, or when the FIFO
// stays empty for TIMEOUT cycles after the most recent pop.
module fifo_packetizer
    import fifo_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 16,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_val,
    input  logic [DATA_WIDTH-1:0] fifo_dataout,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last
);

    localparam int CW = cnt_width(MAX_LEN);
    localparam int TW = cnt_width(TIMEOUT - 1);

    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [CW-1:0]         r_cnt;
    logic [TW-1:0]         r_t;
    logic                  r_last;

    logic w_send;
    logic w_accept;
    logic w_full;
    logic w_decide;
    logic w_decide_last;

    assign w_send   = (r_state == ST_SEND);
    assign w_accept = w_send && out_ready;
    assign w_full   = (r_cnt == MAX_CNT);

    // A word may only leave HOLD once its framing is known: full packet and
    // timeout both close it, a waiting FIFO word keeps it open.
    assign w_decide      = w_full || fifo_val || (r_t == TMO_LAST);
    assign w_decide_last = w_full || !fifo_val;

    // Pops happen only from IDLE or on acceptance of a non-final word; both
    // lead to HOLD, so two pops are never back to back.
    assign fifo_read = !reset &&
                       (((r_state == ST_IDLE) && fifo_val) || (w_accept && !r_last));

    // Output stream is decoded from state so nothing combinational reaches it
    assign out_valid = w_send;
    assign out_data  = w_send ? r_hold : '0;
    assign out_first = w_send && (r_cnt == CNT_ONE);
    assign out_last  = w_send && r_last;

    // Control: FSM, packet word counter and idle timer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_t     <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fifo_read) begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_t     <= '0;
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_decide) begin
                        r_last  <= w_decide_last;
                        r_state <= ST_SEND;
                    end else begin
                        r_t <= r_t + TMR_ONE;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_ONE;
                            r_t     <= '0;
                            r_state <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Hold register captures the FIFO head on every pop; it is left out of
    // reset because out_data is gated by state instead
    always_ff @(posedge clk) begin
        if (fifo_read) begin
            r_hold <= fifo_dataout;
        end
    end

    a_read_spacing: assert property (@(posedge clk) disable iff (reset)
        fifo_read |=> !fifo_read);

    a_read_needs_val: assert property (@(posedge clk) disable iff (reset)
        fifo_read |-> fifo_val);

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        r_cnt <= MAX_CNT);

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_first) && $stable(out_last)));

endmodule
